// File: rtl/cla128_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// cla128_operand_sequencer_if
//   Bus bundle for cla128_operand_sequencer: operand input stream, the
//   connection to the external 128-bit CLA adder, and the result stream.
//
//   Signals:
//     in_valid / in_ready / in_data[31:0] / in_cin   operand word stream
//     add_a[127:0] / add_b[127:0] / add_cin          operands to the adder
//     add_s[127:0] / add_cout                        sum from the adder
//     out_valid / out_ready / out_data[31:0]         result word stream
//     out_last / out_cout                            last-word flag, carry
//     out_ovf (only with CLA_SEQ_SIGNED_OVF_EN)      signed overflow flag
//
//   Modports:
//     master : the sequencer side
//     slave  : the environment (upstream, adder, downstream)
//
//   Optional feature macro: CLA_SEQ_SIGNED_OVF_EN
// ---------------------------------------------------------------------------
interface cla128_operand_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_cin;
    logic [127:0] add_a;
    logic [127:0] add_b;
    logic         add_cin;
    logic [127:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_cout;
`ifdef CLA_SEQ_SIGNED_OVF_EN
    logic         out_ovf;
`endif

    modport master (
        input  in_valid, in_data, in_cin, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_data,
`ifdef CLA_SEQ_SIGNED_OVF_EN
        output out_ovf,
`endif
        output out_last, out_cout
    );

    modport slave (
        output in_valid, in_data, in_cin, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_data,
`ifdef CLA_SEQ_SIGNED_OVF_EN
        input  out_ovf,
`endif
        input  out_last, out_cout
    );
endinterface

// File: rtl/cla128_operand_sequencer.sv
// ---------------------------------------------------------------------------
// cla128_operand_sequencer
//   Collects two 128-bit operands as eight 32-bit words (A words 0-3, then
//   B words 4-7, LSW first), presents them to an external 128-bit CLA adder,
//   waits ADD_WAIT cycles, captures the sum and carry-out, and streams the
//   sum back as four 32-bit words (LSW first).
//
//   Parameters:
//     ADD_WAIT  cycles spent in ADD before the sum is captured (1..15)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    cla128_operand_sequencer_if.master (operand, adder, result)
//
//   Optional feature macro: CLA_SEQ_SIGNED_OVF_EN adds bus.out_ovf, the
//   captured signed-overflow flag, valid with out_last.
// ---------------------------------------------------------------------------
module cla128_operand_sequencer #(
    parameter int unsigned ADD_WAIT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    cla128_operand_sequencer_if.master       bus
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ADD  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ADD_WAIT - 1);

    state_t       r_state;
    state_t       w_next_state;
    logic [2:0]   r_wcnt;
    logic [3:0]   r_wait;
    logic [127:0] r_a;
    logic [127:0] r_b;
    logic         r_cin;
    logic [127:0] r_res;
    logic         r_cout;
`ifdef CLA_SEQ_SIGNED_OVF_EN
    logic         r_ovf;
`endif

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_out_last;
    logic [31:0]  w_out_data;
    logic         w_in_fire;
    logic         w_out_fire;

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_out_last   = 1'b0;
        w_out_data   = '0;
        case (r_state)
            LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_wcnt == 3'd7))
                    w_next_state = ADD;
            end
            ADD: begin
                if (r_wait == 4'd0)
                    w_next_state = SEND;
            end
            SEND: begin
                w_out_valid = 1'b1;
                w_out_last  = (r_wcnt[1:0] == 2'd3);
                w_out_data  = r_res[{r_wcnt[1:0], 5'd0} +: 32];
                if (bus.out_ready && (r_wcnt[1:0] == 2'd3))
                    w_next_state = LOAD;
            end
            default: w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_wcnt  <= '0;
            r_wait  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
`ifdef CLA_SEQ_SIGNED_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        // Counter bit 2 selects B, bits 1:0 the 32-bit slice
                        if (r_wcnt[2])
                            r_b[{r_wcnt[1:0], 5'd0} +: 32] <= bus.in_data;
                        else
                            r_a[{r_wcnt[1:0], 5'd0} +: 32] <= bus.in_data;
                        if (r_wcnt == 3'd0)
                            r_cin <= bus.in_cin;
                        if (r_wcnt == 3'd7) begin
                            r_wcnt <= '0;
                            r_wait <= WAIT_INIT;
                        end else begin
                            r_wcnt <= r_wcnt + 3'd1;
                        end
                    end
                end
                ADD: begin
                    if (r_wait == 4'd0) begin
                        r_res  <= bus.add_s;
                        r_cout <= bus.add_cout;
`ifdef CLA_SEQ_SIGNED_OVF_EN
                        r_ovf  <= (r_a[127] == r_b[127]) && (bus.add_s[127] != r_a[127]);
`endif
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                SEND: begin
                    if (w_out_fire)
                        r_wcnt <= (r_wcnt[1:0] == 2'd3) ? 3'd0 : r_wcnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_last  = w_out_last;
    assign bus.out_cout  = w_out_last ? r_cout : 1'b0;
`ifdef CLA_SEQ_SIGNED_OVF_EN
    assign bus.out_ovf   = w_out_last ? r_ovf : 1'b0;
`endif
    assign bus.add_a     = r_a;
    assign bus.add_b     = r_b;
    assign bus.add_cin   = r_cin;

endmodule

// File: doc/cla128_operand_sequencer.md
CLA128_OPERAND_SEQUENCER -- requirements
Module: cla128_operand_sequencer

Interface
REQ-001 Parameter ADD_WAIT, default 1, SHALL set the cycles spent in ADD before the sum is captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_data holds a valid operand word.
REQ-005 in_ready  output  1  sequencer accepts a word this cycle.
REQ-006 in_data  input  32  operand word, LSW first: words 0-3 = A, words 4-7 = B.
REQ-007 in_cin  input  1  carry-in, sampled with word 0 only.
REQ-008 add_a  output  128  operand A to the 128-bit CLA adder.
REQ-009 add_b  output  128  operand B to the adder.
REQ-010 add_cin  output  1  carry_in to the adder.
REQ-011 add_s  input  128  sum from the adder (combinational).
REQ-012 add_cout  input  1  carry_out from the adder.
REQ-013 out_valid  output  1  out_data holds a valid result word.
REQ-014 out_ready  input  1  downstream accepts a result word.
REQ-015 out_data  output  32  result word, LSW first, 4 words.
REQ-016 out_last  output  1  high with result word 3.
REQ-017 out_cout  output  1  captured carry_out, valid while out_last is high; 0 otherwise.

Function
REQ-018 The block SHALL implement FSM states LOAD, ADD and SEND, with a 3-bit word counter and a 4-bit wait counter.
REQ-019 In LOAD, in_ready SHALL be 1; each cycle with in_valid&in_ready SHALL write in_data into the 32-bit slice of A (count 0-3) or B (count 4-7) selected by the counter, then increment the counter.
REQ-020 The word-0 transfer SHALL also register in_cin into add_cin.
REQ-021 The transfer at count 7 SHALL move the FSM to ADD, clear the word counter, and load the wait counter with ADD_WAIT-1.
REQ-022 add_a, add_b and add_cin SHALL be driven directly from registers and SHALL stay stable from entry to ADD until the next word-0 transfer.
REQ-023 In ADD, in_ready and out_valid SHALL be 0; the wait counter SHALL decrement each cycle, and the cycle it reads 0 SHALL capture add_s into a 128-bit result register and add_cout into a carry register, then go to SEND.
REQ-024 Latency SHALL be exactly ADD_WAIT cycles from the count-7 transfer edge to out_valid=1.
REQ-025 In SEND, out_valid SHALL be 1 and out_data SHALL be result slice [32k+31:32k] for word counter k.
REQ-026 out_data, out_last and out_cout SHALL hold stable while out_valid&!out_ready.
REQ-027 Each out_valid&out_ready SHALL increment k; the transfer at k=3 SHALL return the FSM to LOAD with k=0.
REQ-028 in_ready SHALL be 0 outside LOAD; words offered then SHALL NOT be consumed.
REQ-029 The first LOAD cycle after SEND SHALL accept a word (no bubble); in_valid gaps in LOAD SHALL stall without losing already-loaded words.
REQ-030 Sum arithmetic SHALL be the adder's; the block SHALL NOT modify, truncate or re-add operands.

Reset
REQ-031 With rst_n=0 at a rising edge: FSM=LOAD, both counters=0, A/B/result registers=0, add_cin=0, carry register=0.
REQ-032 During and after reset: in_ready=1 (from the first post-reset cycle), out_valid=0, out_last=0, out_cout=0, out_data=0.
REQ-033 Reset in any state mid-operation SHALL discard partial operands and any unsent result.

Configuration
REQ-034 With macro CLA_SEQ_SIGNED_OVF_EN defined, the block SHALL add output out_ovf (1 bit) = captured (A[127]==B[127]) && (S[127]!=A[127]), valid with out_last, 0 otherwise and at reset.
REQ-035 Without CLA_SEQ_SIGNED_OVF_EN, the out_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset, then A=1, B=1, cin=0 streamed back-to-back -> after ADD_WAIT cycles, words 2,0,0,0; out_last on word 3; out_cout=0.
REQ-037 A=all-ones, B=0, cin=1 -> result words 0,0,0,0; out_cout=1; out_ovf=0 when enabled.
REQ-038 A=0x7FFF..FF, B=1, cin=0 -> MSW=0x80000000, out_cout=0, out_ovf=1 when enabled.
REQ-039 out_ready held low 5 cycles in SEND, with in_valid=1 throughout -> out_data is stable, in_ready=0, and no input word is consumed.
REQ-040 rst_n pulsed low after 5 loaded words, then a full new 8-word operand set -> the result reflects only the new operands.
REQ-041 ADD_WAIT=3, random operands with in_valid gaps -> out_valid rises exactly 3 cycles after the count-7 transfer, and the sum matches the reference model.
